// File: rtl/wb_select_stage.sv
// Writeback-select stage: source/link mux, x0 write suppression, two-entry skid buffer and
// commit counter. Optional link adder enabled by defining WB_SELECT_LINK_EN.
module wb_select_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NSRC = 2,
    parameter int unsigned SELW = $clog2(NSRC + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SELW-1:0]        in_sel,
    input  logic [NSRC*XLEN-1:0]   in_src,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [4:0]             in_rd,
    input  logic                   in_we,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_data,
    output logic [4:0]             out_rd,
    output logic                   out_we,
    output logic [31:0]            commit_cnt
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e          r_state;
    state_e          w_state_next;

    logic [XLEN-1:0] r_main_data;
    logic [4:0]      r_main_rd;
    logic            r_main_we;
    logic [XLEN-1:0] r_skid_data;
    logic [4:0]      r_skid_rd;
    logic            r_skid_we;
    logic [31:0]     r_commit_cnt;

    logic [XLEN-1:0] w_sel_data;
    logic            w_we;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_main_from_skid;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (in_sel == SELW'(i)) begin
                w_sel_data = in_src[i*XLEN +: XLEN];
            end
        end
`ifdef WB_SELECT_LINK_EN
        if (in_sel == SELW'(NSRC)) begin
            w_sel_data = in_pc + XLEN'(4);
        end
`endif
    end

`ifndef WB_SELECT_LINK_EN
    // PC only feeds the link adder, which is absent in this build.
    logic w_unused_pc;
    assign w_unused_pc = ^in_pc;
`endif

    assign w_we       = in_we && (in_rd != 5'd0);
    assign in_ready   = (r_state != StTwo);
    assign out_valid  = (r_state != StEmpty);
    assign w_accept   = in_valid && in_ready;
    assign w_drain    = out_valid && out_ready;
    assign out_data   = r_main_data;
    assign out_rd     = r_main_rd;
    assign out_we     = r_main_we;
    assign commit_cnt = r_commit_cnt;

    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_accept) begin
                    w_state_next = StOne;
                    w_load_main  = 1'b1;
                end
            end
            StOne: begin
                if (w_accept && w_drain) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_next = StTwo;
                    w_load_skid  = 1'b1;
                end else if (w_drain) begin
                    w_state_next = StEmpty;
                end
            end
            StTwo: begin
                if (w_drain) begin
                    w_state_next     = StOne;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StEmpty;
            r_main_data  <= '0;
            r_main_rd    <= '0;
            r_main_we    <= 1'b0;
            r_skid_data  <= '0;
            r_skid_rd    <= '0;
            r_skid_we    <= 1'b0;
            r_commit_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_main) begin
                r_main_data <= w_sel_data;
                r_main_rd   <= in_rd;
                r_main_we   <= w_we;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_rd   <= r_skid_rd;
                r_main_we   <= r_skid_we;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
                r_skid_rd   <= in_rd;
                r_skid_we   <= w_we;
            end
            if (w_drain && r_main_we) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
        end
    end

endmodule
